// File: rtl/a2d_sched.sv
// -----------------------------------------------------------------------------
// a2d_sched
//
// Sequencer that owns the `nxt` request of A2D_intf. It issues one `nxt` pulse
// every PERIOD clocks and follows A2D_intf's round-robin channel order
// (lft_ld -> rght_ld -> batt). CNV_WAIT clocks after each request it captures
// the channel that was just converted. Each channel is block-averaged over
// 2^AVG_LOG rounds. A hysteretic battery-low flag is derived from each new
// battery average.
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   en        in   enable sampling
//   lft_ld    in   [11:0] left load cell from A2D_intf
//   rght_ld   in   [11:0] right load cell from A2D_intf
//   batt      in   [11:0] battery from A2D_intf
//   nxt       out  one-cycle conversion request to A2D_intf
//   chan      out  [1:0] channel of current/next conversion (0=lft,1=rght,2=batt)
//   lft_avg   out  [11:0] averaged left load
//   rght_avg  out  [11:0] averaged right load
//   batt_avg  out  [11:0] averaged battery
//   avg_vld   out  one-cycle strobe: all three averages updated
//   batt_low  out  battery-low flag with hysteresis
// -----------------------------------------------------------------------------
module a2d_sched #(
  parameter int          PERIOD      = 4096,
  parameter int          CNV_WAIT    = 1536,
  parameter int          AVG_LOG     = 2,
  parameter logic [11:0] BATT_LOW_TH = 12'h800,
  parameter logic [11:0] BATT_HYST   = 12'h040
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  input  logic [11:0] batt,
  output logic        nxt,
  output logic [1:0]  chan,
  output logic [11:0] lft_avg,
  output logic [11:0] rght_avg,
  output logic [11:0] batt_avg,
  output logic        avg_vld,
  output logic        batt_low
);

  localparam int PW = $clog2(PERIOD);
  localparam int WW = $clog2(CNV_WAIT + 1);
  localparam int AW = 12 + AVG_LOG;
  localparam int RW = AVG_LOG + 1;

  localparam logic [PW-1:0] P_LAST = PW'(PERIOD - 1);
  localparam logic [WW-1:0] W_LAST = WW'(CNV_WAIT - 1);
  localparam logic [RW-1:0] R_LAST = RW'((1 << AVG_LOG) - 1);
  // Clear threshold is computed in 13 bits so TH+HYST cannot wrap.
  localparam logic [12:0]   CLR_TH = {1'b0, BATT_LOW_TH} + {1'b0, BATT_HYST};

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, GAP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pcnt_q;
  logic [WW-1:0]   wcnt_q;
  logic [RW-1:0]   round_q;
  logic [AW-1:0]   lft_acc_q, rght_acc_q, batt_acc_q;

  logic [11:0]     sel_data;
  logic [AW-1:0]   sel_acc;
  logic [AW-1:0]   sum;
  logic [11:0]     new_batt_avg;
  logic            round_done;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (wcnt_q == W_LAST) state_d = CAPTURE;
      CAPTURE: state_d = GAP;
      GAP:     if (pcnt_q == P_LAST) state_d = en ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request is decoded straight from the state register, so an async reset
  // during ISSUE drops it in the same cycle.
  assign nxt = (state_q == ISSUE);

  // ---------------------------------------------------------------------------
  // Capture datapath: the channel being captured is the one chan points at.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_data = batt;
    sel_acc  = batt_acc_q;
    case (chan)
      2'd0: begin sel_data = lft_ld;  sel_acc = lft_acc_q;  end
      2'd1: begin sel_data = rght_ld; sel_acc = rght_acc_q; end
      default: ;
    endcase
  end

  assign sum          = sel_acc + AW'(sel_data);
  assign round_done   = (chan == 2'd2) && (round_q == R_LAST);
  // On the completing capture, chan is batt, so sum is the final batt total.
  assign new_batt_avg = sum[AVG_LOG +: 12];

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // NOTE: every register here is updated with <= so all of them see the same
  // pre-edge values; blocking writes would make results depend on line order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pcnt_q     <= '0;
      wcnt_q     <= '0;
      round_q    <= '0;
      chan       <= 2'd0;
      lft_acc_q  <= '0;
      rght_acc_q <= '0;
      batt_acc_q <= '0;
      lft_avg    <= '0;
      rght_avg   <= '0;
      batt_avg   <= '0;
      avg_vld    <= 1'b0;
      batt_low   <= 1'b0;
    end else begin
      state_q <= state_d;

      // Period count is 0 during ISSUE, so GAP sees PERIOD-1 exactly one
      // cycle before the next ISSUE.
      if (state_d == ISSUE)
        pcnt_q <= '0;
      else if (state_q != IDLE)
        pcnt_q <= pcnt_q + 1'b1;

      if (state_q == ISSUE)
        wcnt_q <= '0;
      else if (state_q == WAIT)
        wcnt_q <= wcnt_q + 1'b1;

      avg_vld <= (state_q == CAPTURE) && round_done;

      if (state_q == CAPTURE) begin
        chan <= (chan == 2'd2) ? 2'd0 : chan + 2'd1;

        if (round_done) begin
          lft_avg    <= lft_acc_q[AVG_LOG +: 12];
          rght_avg   <= rght_acc_q[AVG_LOG +: 12];
          batt_avg   <= new_batt_avg;
          lft_acc_q  <= '0;
          rght_acc_q <= '0;
          batt_acc_q <= '0;
          round_q    <= '0;
          if (new_batt_avg < BATT_LOW_TH)
            batt_low <= 1'b1;
          else if ({1'b0, new_batt_avg} > CLR_TH)
            batt_low <= 1'b0;
        end else begin
          case (chan)
            2'd0:    lft_acc_q  <= sum;
            2'd1:    rght_acc_q <= sum;
            default: batt_acc_q <= sum;
          endcase
          if (chan == 2'd2)
            round_q <= round_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_a2d_sched.sv
// -----------------------------------------------------------------------------
// tb_a2d_sched
//
// Directed bench for a2d_sched with a short period. The main process plays
// the A2D_intf stub (drives lft_ld/rght_ld/batt per round) and pushes the
// hand-computed averages it expects. The monitor watches nxt, chan and avg_vld
// on the falling edge and pops/compares whenever avg_vld is seen.
// -----------------------------------------------------------------------------
module tb_a2d_sched;

  localparam int PERIOD   = 64;
  localparam int CNV_WAIT = 40;
  localparam int AVG_LOG  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [11:0] lft_ld, rght_ld, batt;
  logic        nxt;
  logic [1:0]  chan;
  logic [11:0] lft_avg, rght_avg, batt_avg;
  logic        avg_vld;
  logic        batt_low;

  a2d_sched #(
    .PERIOD      (PERIOD),
    .CNV_WAIT    (CNV_WAIT),
    .AVG_LOG     (AVG_LOG),
    .BATT_LOW_TH (12'h800),
    .BATT_HYST   (12'h040)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .lft_ld   (lft_ld),
    .rght_ld  (rght_ld),
    .batt     (batt),
    .nxt      (nxt),
    .chan     (chan),
    .lft_avg  (lft_avg),
    .rght_avg (rght_avg),
    .batt_avg (batt_avg),
    .avg_vld  (avg_vld),
    .batt_low (batt_low)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] l;
    logic [11:0] r;
    logic [11:0] b;
    logic        low;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int total = 0;
  int bad   = 0;

  // Monitor-owned bookkeeping.
  int         cyc            = 0;
  int         cap_cnt        = 0;
  int         caps_since_rst = 0;
  int         nxt_cnt        = 0;
  int         last_nxt_cyc   = 0;
  int         last_nxt_epoch = 0;
  logic       last_nxt_valid = 1'b0;
  logic       prev_nxt       = 1'b0;
  logic [1:0] prev_chan      = 2'd0;

  // Main-owned: bumped whenever the bench deliberately breaks the nxt cadence.
  int epoch = 0;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [11:0] l, input logic [11:0] r,
                              input logic [11:0] b, input logic low);
    exp_t e;
    e.l = l; e.r = r; e.b = b; e.low = low;
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_chan      = 2'd0;
      prev_nxt       = 1'b0;
      caps_since_rst = 0;
      last_nxt_valid = 1'b0;
    end else begin
      if (nxt) begin
        check("nxt_single_cycle", 32'(prev_nxt), 0);
        if (last_nxt_valid && last_nxt_epoch == epoch)
          check("nxt_period", cyc - last_nxt_cyc, PERIOD);
        last_nxt_cyc   = cyc;
        last_nxt_epoch = epoch;
        last_nxt_valid = 1'b1;
        nxt_cnt++;
      end
      if (chan != prev_chan) begin
        check("chan_step", 32'(chan), (32'(prev_chan) + 1) % 3);
        // Capture happens CNV_WAIT+1 cycles after nxt; chan shows the
        // advance one cycle later.
        check("capture_latency", cyc - last_nxt_cyc, CNV_WAIT + 2);
        cap_cnt++;
        caps_since_rst++;
      end
      if (avg_vld) begin
        check("avg_vld_after_12_caps", caps_since_rst % 12, 0);
        check("avg_vld_expected", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check("lft_avg",  32'(lft_avg),  32'(mon_e.l));
          check("rght_avg", 32'(rght_avg), 32'(mon_e.r));
          check("batt_avg", 32'(batt_avg), 32'(mon_e.b));
          check("batt_low", 32'(batt_low), 32'(mon_e.low));
        end
      end
      prev_nxt  = nxt;
      prev_chan = chan;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic wait_caps(input int n);
    int start;
    int budget;
    start  = cap_cnt;
    budget = (n + 2) * PERIOD;
    while ((cap_cnt - start) < n && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    check("capture_count", cap_cnt - start, n);
  endtask

  task automatic wait_nxt(input int limit);
    int start;
    int budget;
    start  = nxt_cnt;
    budget = limit;
    while (nxt_cnt == start && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    check("nxt_seen", nxt_cnt - start, 1);
  endtask

  // Four rounds; index 0 is the first round.
  task automatic run_block(input logic [3:0][11:0] l, input logic [3:0][11:0] r,
                           input logic [3:0][11:0] b, input exp_t e);
    sb_q.push_back(e);
    for (int i = 0; i < 4; i++) begin
      lft_ld  = l[i];
      rght_ld = r[i];
      batt    = b[i];
      wait_caps(3);
    end
  endtask

  task automatic run_const(input logic [11:0] l, input logic [11:0] r,
                           input logic [11:0] b, input logic low);
    run_block({4{l}}, {4{r}}, {4{b}}, mk(l, r, b, low));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_nxt"},      32'(nxt),      0);
    check({tag, "_chan"},     32'(chan),     0);
    check({tag, "_lft_avg"},  32'(lft_avg),  0);
    check({tag, "_rght_avg"}, 32'(rght_avg), 0);
    check({tag, "_batt_avg"}, 32'(batt_avg), 0);
    check({tag, "_avg_vld"},  32'(avg_vld),  0);
    check({tag, "_batt_low"}, 32'(batt_low), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int c0;
    int held;
    int n0;

    rst_n   = 1'b0;
    en      = 1'b0;
    lft_ld  = '0;
    rght_ld = '0;
    batt    = '0;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    #2 rst_n = 1'b1;

    // Idle with en low: nothing happens.
    repeat (5) @(negedge clk);
    #1;
    check("idle_no_nxt", nxt_cnt, 0);
    check("idle_chan", 32'(chan), 0);

    en = 1'b1;

    // Averaging: lft ramps 0x100..0x106 -> 0x103.
    run_block({12'h106, 12'h104, 12'h102, 12'h100},
              {4{12'h200}}, {4{12'hA00}},
              mk(12'h103, 12'h200, 12'hA00, 1'b0));

    // Full-scale inputs.
    run_const(12'hFFF, 12'hFFF, 12'hFFF, 1'b0);

    // Truncation: (1+2+2+2)/4 = 1.
    run_block({12'h002, 12'h002, 12'h002, 12'h001},
              {12'h002, 12'h002, 12'h002, 12'h001},
              {4{12'hA00}},
              mk(12'h001, 12'h001, 12'hA00, 1'b0));

    // Hysteresis walk.
    run_const(12'h111, 12'h222, 12'h7FF, 1'b1);
    run_const(12'h333, 12'h444, 12'h830, 1'b1);
    run_const(12'h555, 12'h666, 12'h840, 1'b1);
    run_const(12'h777, 12'h888, 12'h841, 1'b0);
    run_const(12'h999, 12'hAAA, 12'h800, 1'b0);

    // Enable drop during WAIT of the lft conversion.
    lft_ld  = 12'h321;
    rght_ld = 12'h654;
    batt    = 12'h700;
    sb_q.push_back(mk(12'h321, 12'h654, 12'h700, 1'b1));
    wait_nxt(2 * PERIOD);
    repeat (10) @(negedge clk);
    en = 1'b0;
    epoch++;
    c0 = 32'(chan);
    wait_caps(1);
    check("en_drop_capture_chan", 32'(chan), (c0 + 1) % 3);
    held = 32'(chan);
    n0   = nxt_cnt;
    repeat (500) @(negedge clk);
    #1;
    check("no_nxt_while_disabled", nxt_cnt - n0, 0);
    check("chan_held", 32'(chan), held);
    en = 1'b1;
    wait_nxt(PERIOD);
    check("resume_chan", 32'(chan), held);
    wait_caps(11);

    // Reset mid-WAIT of the batt conversion in round 3.
    lft_ld  = 12'h555;
    rght_ld = 12'h555;
    batt    = 12'h555;
    wait_caps(8);
    check("pre_reset_chan", 32'(chan), 2);
    wait_nxt(2 * PERIOD);
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Fresh four rounds from chan 0 after reset.
    run_const(12'h0AA, 12'h0BB, 12'hC00, 1'b0);

    repeat (4) @(negedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
